// File: rtl/seg7_pkg.sv
// seg7_pkg: segment patterns, state and result types shared by the readback encoder
package seg7_pkg;
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0011000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  typedef enum logic {TRACK, HOLD} state_t;
  typedef struct packed {
    logic [3:0] value;
    logic       err;
  } result_t;
endpackage

// File: rtl/seg7_pattern_lookup.sv
// seg7_pattern_lookup: maps a digit/sign segment pair back to a 4-bit value or flags it illegal
module seg7_pattern_lookup
  import seg7_pkg::*;
#(
  parameter bit SIGNED_MODE = 1'b1
) (
  input  logic [6:0] numHEX,
  input  logic [6:0] signHEX,
  output logic [3:0] value,
  output logic       err
);
  logic [3:0] dig;
  logic dok, blank, minus, ok;
  always_comb begin
    dig = 4'h0;
    dok = 1'b1;
    case (numHEX)
      SEG_0: dig = 4'h0;
      SEG_1: dig = 4'h1;
      SEG_2: dig = 4'h2;
      SEG_3: dig = 4'h3;
      SEG_4: dig = 4'h4;
      SEG_5: dig = 4'h5;
      SEG_6: dig = 4'h6;
      SEG_7: dig = 4'h7;
      SEG_8: dig = 4'h8;
      SEG_9: dig = 4'h9;
      SEG_A: dig = 4'hA;
      SEG_B: dig = 4'hB;
      SEG_C: dig = 4'hC;
      SEG_D: dig = 4'hD;
      SEG_E: dig = 4'hE;
      SEG_F: dig = 4'hF;
      default: dok = 1'b0;
    endcase
    blank = signHEX == SEG_BLANK;
    minus = signHEX == SEG_MINUS;
    ok = SIGNED_MODE ? dok && ((blank && dig < 4'd8) || (minus && dig >= 4'd1 && dig <= 4'd8))
                     : dok && blank;
    err = !ok;
    value = !ok ? 4'd0 : minus ? 4'd0 - dig : dig;
  end
endmodule

// File: rtl/seg7_readback_encoder.sv
// seg7_readback_encoder: debounces the displayed segment pair and emits its encoded value once per new pattern
module seg7_readback_encoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter bit SIGNED_MODE   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] numHEX,
  input  logic [6:0] signHEX,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_value,
  output logic       out_err,
  output logic [7:0] err_count
);
  localparam logic [7:0] SC = 8'(STABLE_CYCLES);
  logic [6:0] num_q, num_d, sign_q, sign_d;
  logic [7:0] cnt_q, cnt_d, errc_q, errc_d;
  logic [13:0] last_q, last_d;
  logic last_ok_q, last_ok_d, same, fire, acc, lk_err;
  logic [3:0] lk_value;
  state_t state_q, state_d;
  result_t res_q, res_d;
  seg7_pattern_lookup #(.SIGNED_MODE(SIGNED_MODE)) u_lookup (
    .numHEX (num_q),
    .signHEX(sign_q),
    .value  (lk_value),
    .err    (lk_err)
  );
  always_comb begin
    num_d = numHEX;
    sign_d = signHEX;
    same = {numHEX, signHEX} == {num_q, sign_q};
    cnt_d = !same ? 8'd0 : cnt_q == SC ? cnt_q : cnt_q + 8'd1;
    fire = state_q == TRACK && same && cnt_q >= SC - 8'd1
           && (!last_ok_q || last_q != {num_q, sign_q});
    acc = state_q == HOLD && out_ready;
    state_d = fire ? HOLD : acc ? TRACK : state_q;
    res_d = fire ? result_t'{lk_value, lk_err} : res_q;
    last_d = fire ? {num_q, sign_q} : last_q;
    last_ok_d = last_ok_q | fire;
    errc_d = acc && res_q.err && errc_q != 8'hFF ? errc_q + 8'd1 : errc_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      num_q <= SEG_BLANK;
      sign_q <= SEG_BLANK;
      cnt_q <= 8'd0;
      errc_q <= 8'd0;
      last_q <= 14'd0;
      last_ok_q <= 1'b0;
      state_q <= TRACK;
      res_q <= '0;
    end else begin
      num_q <= num_d;
      sign_q <= sign_d;
      cnt_q <= cnt_d;
      errc_q <= errc_d;
      last_q <= last_d;
      last_ok_q <= last_ok_d;
      state_q <= state_d;
      res_q <= res_d;
    end
  end
  assign out_valid = state_q == HOLD;
  assign out_value = res_q.value;
  assign out_err = res_q.err;
  assign err_count = errc_q;
endmodule

// File: tb/tb_seg7_readback_encoder.sv
// tb_seg7_readback_encoder: run-length model of signed and unsigned encoders plus directed literal checks
module tb_seg7_readback_encoder;
  localparam int S = 4;
  logic clk = 1'b0, rst = 1'b1, out_ready = 1'b1;
  logic [6:0] numHEX = 7'h7F, signHEX = 7'h7F;
  logic v_s, v_u, e_s, e_u;
  logic [3:0] val_s, val_u;
  logic [7:0] c_s, c_u;
  int checks = 0, errors = 0;
  bit chk = 0;

  always #5 clk = ~clk;

  seg7_readback_encoder #(.STABLE_CYCLES(S), .SIGNED_MODE(1'b1)) dut_s (
    .clk(clk), .rst(rst), .numHEX(numHEX), .signHEX(signHEX), .out_valid(v_s),
    .out_ready(out_ready), .out_value(val_s), .out_err(e_s), .err_count(c_s));
  seg7_readback_encoder #(.STABLE_CYCLES(S), .SIGNED_MODE(1'b0)) dut_u (
    .clk(clk), .rst(rst), .numHEX(numHEX), .signHEX(signHEX), .out_valid(v_u),
    .out_ready(out_ready), .out_value(val_u), .out_err(e_u), .err_count(c_u));

  logic [6:0] tbl [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
                           7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  task automatic cmp(input string n, input logic [7:0] a, input logic [7:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", n, a, e, $time);
    end
  endtask

  function automatic void dec(input logic [13:0] p, input bit sm, output logic [3:0] v, output logic e);
    int d = -1, sv = 0;
    bit ok = 0;
    for (int i = 0; i < 16; i++) if (tbl[i] == p[13:7]) d = i;
    if (d >= 0 && p[6:0] == 7'h7F) begin
      ok = sm ? d <= 7 : 1;
      sv = d;
    end else if (d >= 0 && p[6:0] == 7'h3F && sm) begin
      ok = d >= 1 && d <= 8;
      sv = 16 - d;
    end
    e = !ok;
    v = ok ? 4'(sv) : 4'd0;
  endfunction

  // model: index 1 = signed instance, 0 = unsigned instance
  logic m_valid, last_ok;
  logic [13:0] prev, last;
  int run;
  logic [3:0] m_val [2];
  logic m_err [2];
  int m_cnt [2];

  always @(posedge clk) begin
    logic [13:0] p;
    p = {numHEX, signHEX};
    if (rst) begin
      m_valid = 0; last_ok = 0; prev = 14'h3FFF; run = 1; last = 0;
      for (int m = 0; m < 2; m++) begin m_val[m] = 0; m_err[m] = 0; m_cnt[m] = 0; end
    end else begin
      run = (p == prev) ? (run < 1000 ? run + 1 : run) : 1;
      prev = p;
      if (m_valid) begin
        if (out_ready) begin
          m_valid = 0;
          for (int m = 0; m < 2; m++) if (m_err[m] && m_cnt[m] < 255) m_cnt[m]++;
        end
      end else if (run >= S + 1 && (!last_ok || p != last)) begin
        m_valid = 1; last = p; last_ok = 1;
        for (int m = 0; m < 2; m++) dec(p, m == 1, m_val[m], m_err[m]);
      end
    end
  end

  always @(negedge clk) if (chk) begin
    cmp("valid_s", {7'd0, v_s}, {7'd0, m_valid});
    cmp("valid_u", {7'd0, v_u}, {7'd0, m_valid});
    cmp("value_s", {4'd0, val_s}, {4'd0, m_val[1]});
    cmp("value_u", {4'd0, val_u}, {4'd0, m_val[0]});
    cmp("err_s", {7'd0, e_s}, {7'd0, m_err[1]});
    cmp("err_u", {7'd0, e_u}, {7'd0, m_err[0]});
    cmp("count_s", c_s, 8'(m_cnt[1]));
    cmp("count_u", c_u, 8'(m_cnt[0]));
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!v_s && n < 40);
    if (!v_s) begin
      errors++;
      $display("FAIL wait_valid actual=timeout expected=valid t=%0t", $time);
    end
  endtask

  task automatic drive(input logic [6:0] n, input logic [6:0] s);
    numHEX = n;
    signHEX = s;
  endtask

  initial begin
    int n, v;
    step();
    chk = 1;
    step();
    cmp("rst_valid", {7'd0, v_s}, 8'd0);
    cmp("rst_count", c_u, 8'd0);
    rst = 0;
    drive(7'b1111001, 7'h7F);
    step();
    wait_valid(n);
    cmp("lat1", 8'(n), 8'd4);
    cmp("one_value", {4'd0, val_s}, 8'd1);
    cmp("one_err", {7'd0, e_s}, 8'd0);
    v = 0;
    repeat (10) begin step(); v += int'(v_s); end
    cmp("no_reemit", 8'(v), 8'd0);
    drive(7'b0000000, 7'b0111111);
    wait_valid(n);
    cmp("neg8_s", {3'd0, val_s, e_s}, 8'b10000);
    cmp("neg8_u", {3'd0, val_u, e_u}, 8'b00001);
    step();
    cmp("neg8_cnt_u", c_u, 8'd1);
    drive(7'b0110000, 7'h7F);
    repeat (2) step();
    drive(7'b0010010, 7'h7F);
    wait_valid(n);
    cmp("glitch_val", {4'd0, val_s}, 8'd5);
    step();
    out_ready = 0;
    drive(7'b0000010, 7'h7F);
    wait_valid(n);
    drive(7'b1111000, 7'h7F);
    repeat (10) step();
    cmp("hold_valid", {7'd0, v_s}, 8'd1);
    cmp("hold_val", {4'd0, val_s}, 8'd6);
    out_ready = 1;
    step();
    cmp("idle", {7'd0, v_s}, 8'd0);
    wait_valid(n);
    cmp("idle_gap", 8'(n), 8'd1);
    cmp("seven", {4'd0, val_s}, 8'd7);
    step();
    out_ready = 0;
    drive(7'b0100100, 7'h7F);
    wait_valid(n);
    cmp("two", {4'd0, val_s}, 8'd2);
    rst = 1;
    step();
    cmp("rst_hold", {3'd0, val_s, v_s}, 8'd0);
    rst = 0;
    out_ready = 1;
    wait_valid(n);
    cmp("rst_lat", 8'(n), 8'(S + 1));
    cmp("two_again", {4'd0, val_s}, 8'd2);
    step();
    for (int i = 0; i < 260; i++) begin
      drive(i % 2 == 0 ? 7'b1010101 : 7'b0101010, 7'h7F);
      wait_valid(n);
      step();
    end
    cmp("sat_s", c_s, 8'd255);
    cmp("sat_u", c_u, 8'd255);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seg7_readback_encoder.md
Name: seg7_readback_encoder

Overview:
- Inverse of the signed 7-segment digit decoder. Samples an active-low digit pattern and a sign pattern, the same pair driven to HEX0/HEX1, and encodes them back into a 4-bit value.
- Waits until the pair has been stable for a programmable number of cycles, then hands the result out on a valid/ready interface, once per distinct stable pattern.
- Sits between the display outputs and the BitBlaster self-test/readback logic, so that displayed values can be checked against register contents.

Parameters:
- STABLE_CYCLES, 4: consecutive identical samples required before emission; legal range 1..255.
- SIGNED_MODE, 1: 1 = decode as 4-bit two's complement (-8..7); 0 = decode as an unsigned hex digit (0..F).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- numHEX  in  7  active-low digit segments {g,f,e,d,c,b,a}.
- signHEX  in  7  active-low sign segments.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result when out_valid && out_ready at an edge.
- out_value  out  4  encoded value (two's complement when SIGNED_MODE=1).
- out_err  out  1  captured pattern was not a legal encoding; out_value=0 in that case.
- err_count  out  8  saturating count of emitted results with out_err=1.

Behaviour:
- Reset (rst=1 at an edge): out_valid=0, out_value=0, out_err=0, err_count=0, state=TRACK, stable counter=0, sample registers=7'h7F/7'h7F (blank), last-emitted-valid flag=0. Reset overrides every other event, including an in-flight HOLD handshake.
- Digit table, pattern -> digit:
  - 1000000=0, 1111001=1, 0100100=2, 0110000=3, 0011001=4
  - 0010010=5, 0000010=6, 1111000=7, 0000000=8, 0011000=9
  - 0001000=A, 0000011=b, 1000110=C, 0100001=d, 0000110=E, 0001110=F
  - Any other digit pattern is illegal.
- Sign table: 1111111=blank, 0111111=minus; anything else is illegal.
- SIGNED_MODE=1:
  - blank + digit 0..7 -> value = digit.
  - minus + digit 1..8 -> value = -digit in 4-bit two's complement (minus+8 -> 4'b1000).
  - blank + 8..F, minus + 0, minus + 9..F -> illegal.
- SIGNED_MODE=0: blank + any digit 0..F -> value = digit; minus -> illegal.
- Sampling: numHEX/signHEX are registered every cycle into the 14-bit sample register.
  - If the new sample differs from the held sample, the stable counter clears to 0.
  - Otherwise the counter increments, saturating at STABLE_CYCLES.
- State TRACK:
  - Condition: counter reaches STABLE_CYCLES-1 on an equal sample, AND (last-emitted flag=0 OR pattern differs from the last-emitted pattern).
  - Action: load out_value/out_err, assert out_valid, store the pattern as last-emitted, set the flag, go to HOLD.
  - Latency: a pattern first present at the inputs before edge k gives out_valid=1 after edge k+STABLE_CYCLES.
- State HOLD:
  - out_valid, out_value and out_err stay constant until acceptance. Input changes during HOLD are still tracked by the counter but do not alter the outputs.
  - On out_valid && out_ready: out_valid=0 next cycle; err_count += out_err, saturating at 255; return to TRACK.
  - If the inputs already show a new pattern that is stable long enough, the next emission may occur at the earliest one cycle after acceptance (out_valid low for at least one cycle).
- No re-emission: a pattern identical to the last-emitted one is never emitted again, however long it persists. It becomes eligible again only after a different pattern has been emitted.
- Glitch rejection: a change lasting fewer than STABLE_CYCLES samples produces no emission.

Decomposition:
- Package seg7_pkg holds:
  - the 16 digit-pattern localparams, SEG_BLANK and SEG_MINUS;
  - a state enum typedef {TRACK, HOLD};
  - a struct typedef for the captured result {value[3:0], err}.
- One combinational sub-module, seg7_pattern_lookup (inputs: numHEX, signHEX; parameter: SIGNED_MODE; outputs: value, err). It is reusable by the bench as a scoreboard reference.
- The top holds the sampler, stability counter, state machine and error counter.

Test Plan:
- Reset, then hold numHEX=1111001 (1), signHEX=1111111, out_ready=1, STABLE_CYCLES=4 -> out_valid high one cycle exactly 4 edges after first sample; out_value=4'b0001, out_err=0; no second emission while the pattern persists.
- numHEX=0000000, signHEX=0111111, SIGNED_MODE=1 -> out_value=4'b1000, out_err=0. The same pattern with SIGNED_MODE=0 -> out_err=1, out_value=0, err_count=1.
- Drive 0110000/blank (3) for 2 cycles, then 0010010/blank (5) steadily -> single emission of value 5 only.
- Stable 0000010/blank (6) with out_ready=0 for 10 cycles, inputs change to 7 meanwhile -> out_value stays 6 with out_valid high. Raise out_ready -> 6 accepted, then 7 emitted after at least one idle cycle.
- Emit value 2, assert rst for one cycle while in HOLD, keep the same inputs -> outputs cleared, then value 2 re-emitted STABLE_CYCLES cycles after reset deasserts.
- 260 emissions of illegal patterns (alternating 1010101 and 0101010 digits, each stable and accepted) -> err_count saturates at 255.
